// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg
// Shared definitions for the debug-display scheduler: default widths,
// the {Time, Val} entry record and the FIFO pointer-width helper.
package disp_sched_pkg;

  localparam int DISP_WIDTH_DEF = 32;
  localparam int TIME_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 8;

  typedef struct packed {
    logic [TIME_WIDTH_DEF-1:0] Time;
    logic [DISP_WIDTH_DEF-1:0] Val;
  } entry_t;

  // One extra MSB beyond the address bits distinguishes full from empty
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/disp_sched_if.sv
// disp_sched_if
// Requester-side handshake bundle: two independent valid/ready channels
// (A = host software, B = hex-file loader), each carrying a start cycle
// and a display word.
interface disp_sched_if
  import disp_sched_pkg::*;
#(
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int TIME_WIDTH = TIME_WIDTH_DEF
);

  logic                  AValid;
  logic [TIME_WIDTH-1:0] ATime;
  logic [DISP_WIDTH-1:0] AVal;
  logic                  AReady;

  logic                  BValid;
  logic [TIME_WIDTH-1:0] BTime;
  logic [DISP_WIDTH-1:0] BVal;
  logic                  BReady;

  modport master (
    output AValid, ATime, AVal, BValid, BTime, BVal,
    input  AReady, BReady
  );

  modport slave (
    input  AValid, ATime, AVal, BValid, BTime, BVal,
    output AReady, BReady
  );

endinterface

// File: rtl/disp_sched_fifo.sv
// disp_sched_fifo
// Synchronous FIFO holding pending display entries in arrival order.
// The head is presented combinationally so the release logic can compare
// its start cycle against the running counter in the same cycle.
module disp_sched_fifo
  import disp_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = $bits(entry_t)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[PW-1] != r_rdPtr[PW-1]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Advance read/write pointers; reset flushes everything queued
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until the write pointer passes them
  always_ff @(posedge Clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/disp_sched.sv
// disp_sched
// Runtime scheduler for the debug-display control word. Two requesters are
// arbitrated round-robin into a time-ordered FIFO; a saturating cycle counter
// releases the head entry once its start cycle is reached, updating DispValOut.
// Optional feature: define DISP_SCHED_ORDER_CHECK_EN to drop (and flag on Err)
// any accepted entry whose start cycle precedes the last stored one.
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int DISP_WIDTH = DISP_WIDTH_DEF,
  parameter int TIME_WIDTH = TIME_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  disp_sched_if.slave           bus,
  output logic [DISP_WIDTH-1:0] DispValOut,
  output logic [TIME_WIDTH-1:0] CycleNo,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Err
);

  logic                  r_prioB;
  logic [TIME_WIDTH-1:0] r_cycle;
  logic [DISP_WIDTH-1:0] r_disp;
  logic                  r_err;

  logic   w_empty;
  logic   w_full;
  logic   w_grantA;
  logic   w_grantB;
  logic   w_accept;
  logic   w_reject;
  logic   w_push;
  logic   w_pop;
  entry_t w_pushEntry;
  entry_t w_head;

  // Full reflects start-of-cycle occupancy, so a same-cycle release never frees a slot early
  assign w_grantA = !Reset && !w_full && bus.AValid && (!bus.BValid || !r_prioB);
  assign w_grantB = !Reset && !w_full && bus.BValid && (!bus.AValid ||  r_prioB);
  assign w_accept = w_grantA || w_grantB;

  assign bus.AReady = w_grantA;
  assign bus.BReady = w_grantB;

  assign w_pushEntry.Time = w_grantA ? bus.ATime : bus.BTime;
  assign w_pushEntry.Val  = w_grantA ? bus.AVal  : bus.BVal;

  assign w_pop  = !w_empty && (r_cycle >= w_head.Time);
  assign w_push = w_accept && !w_reject;

`ifdef DISP_SCHED_ORDER_CHECK_EN
  logic [TIME_WIDTH-1:0] r_lastTime;

  assign w_reject = w_accept && (w_pushEntry.Time < r_lastTime);

  // Remember the start cycle of the most recently stored entry
  always_ff @(posedge Clk) begin
    if (Reset)       r_lastTime <= '0;
    else if (w_push) r_lastTime <= w_pushEntry.Time;
  end
`else
  assign w_reject = 1'b0;
`endif

  disp_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_data  (w_pushEntry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Cycle counter, display register, arbitration pointer and error pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cycle <= '0;
      r_disp  <= '0;
      r_prioB <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
      if (w_pop) r_disp <= w_head.Val;
      if (bus.AValid && bus.BValid && w_accept) r_prioB <= !r_prioB;
      r_err <= w_reject;
    end
  end

  assign DispValOut = r_disp;
  assign CycleNo    = r_cycle;
  assign Empty      = w_empty;
  assign Full       = w_full;
  assign Err        = r_err;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched
// Self-checking bench for disp_sched. A queue-based model of the scheduler
// predicts every output each cycle; directed scenarios add literal
// expectations. Build with DISP_SCHED_ORDER_CHECK_EN to cover the order check.
module tb_disp_sched;
  import disp_sched_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] DispValOut;
  logic [31:0] CycleNo;
  logic        Empty;
  logic        Full;
  logic        Err;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  disp_sched_if #(.DISP_WIDTH(32), .TIME_WIDTH(32)) bus ();

  disp_sched #(
    .DISP_WIDTH (32),
    .TIME_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus),
    .DispValOut (DispValOut),
    .CycleNo    (CycleNo),
    .Empty      (Empty),
    .Full       (Full),
    .Err        (Err)
  );

  // Scheduler model state
  entry_t      mq[$];
  logic [31:0] mCyc;
  logic [31:0] mDisp;
  logic [31:0] mLast;
  bit          mPrioB;
  bit          mErr;
  bit          armed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [31:0] aT, input logic [31:0] aVal,
                               input logic bV, input logic [31:0] bT, input logic [31:0] bVal);
    bus.AValid = aV;
    bus.ATime  = aT;
    bus.AVal   = aVal;
    bus.BValid = bV;
    bus.BTime  = bT;
    bus.BVal   = bVal;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    nextCycle();
    Reset = 1'b0;
  endtask

  // Which requester the arbitration rules grant now: bit0 = A, bit1 = B
  function automatic logic [1:0] modelGrant();
    if (Reset || mq.size() >= DEPTH) return 2'b00;
    if (bus.AValid && bus.BValid) return mPrioB ? 2'b10 : 2'b01;
    return {bus.BValid, bus.AValid};
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model across the next edge
  initial begin
    forever begin
      logic [1:0] g;
      entry_t     e;
      entry_t     h;
      @(negedge Clk);
      g = modelGrant();
      if (armed) begin
        checkOutput("AReady", {63'd0, bus.AReady}, {63'd0, g[0]});
        checkOutput("BReady", {63'd0, bus.BReady}, {63'd0, g[1]});
        checkOutput("CycleNo", {32'd0, CycleNo}, {32'd0, mCyc});
        checkOutput("DispValOut", {32'd0, DispValOut}, {32'd0, mDisp});
        checkOutput("Empty", {63'd0, Empty}, {63'd0, mq.size() == 0});
        checkOutput("Full", {63'd0, Full}, {63'd0, mq.size() == DEPTH});
        checkOutput("Err", {63'd0, Err}, {63'd0, mErr});
      end
      if (Reset) begin
        mq.delete();
        mCyc   = 32'd0;
        mDisp  = 32'd0;
        mLast  = 32'd0;
        mPrioB = 1'b0;
        mErr   = 1'b0;
        armed  = 1'b1;
      end else begin
        if (mq.size() > 0 && mCyc >= mq[0].Time) begin
          h = mq.pop_front();
          mDisp = h.Val;
        end
        mErr = 1'b0;
        if (g != 2'b00) begin
          e.Time = g[0] ? bus.ATime : bus.BTime;
          e.Val  = g[0] ? bus.AVal  : bus.BVal;
`ifdef DISP_SCHED_ORDER_CHECK_EN
          if (e.Time < mLast) begin
            mErr = 1'b1;
          end else begin
            mq.push_back(e);
            mLast = e.Time;
          end
`else
          mq.push_back(e);
`endif
        end
        if (bus.AValid && bus.BValid && g != 2'b00) mPrioB = !mPrioB;
        if (mCyc != 32'hFFFF_FFFF) mCyc = mCyc + 32'd1;
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);

    // Single entry with Time=5: visible once CycleNo reaches 6
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c == 0, 32'd5, 32'h0000_0001, 1'b0, 32'd0, 32'd0);
      @(negedge Clk);
      if (c == 0) begin
        checkOutput("resetCycleNo", {32'd0, CycleNo}, 64'd0);
        checkOutput("resetDisp", {32'd0, DispValOut}, 64'd0);
        checkOutput("resetFull", {63'd0, Full}, 64'd0);
        checkOutput("resetErr", {63'd0, Err}, 64'd0);
        checkOutput("firstAReady", {63'd0, bus.AReady}, 64'd1);
      end
      if (c == 5) checkOutput("dispBeforeT", {32'd0, DispValOut}, 64'd0);
      if (c == 6) checkOutput("dispAtT1", {32'd0, DispValOut}, 64'd1);
      nextCycle();
    end

    // Both requesters streaming: alternating grants until full
    doReset();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, 32'd1000, 32'hA, 1'b1, 32'd1000, 32'hB);
      @(negedge Clk);
      if (c < 8) begin
        checkOutput("rrAReady", {63'd0, bus.AReady}, {63'd0, (c % 2) == 0});
        checkOutput("rrBReady", {63'd0, bus.BReady}, {63'd0, (c % 2) == 1});
      end else begin
        checkOutput("fullAReady", {63'd0, bus.AReady}, 64'd0);
        checkOutput("fullBReady", {63'd0, bus.BReady}, 64'd0);
        checkOutput("fullFlag", {63'd0, Full}, 64'd1);
      end
      nextCycle();
    end

    // Full FIFO releasing its head: push refused that cycle, taken the next
    doReset();
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c <= 21, (c == 0) ? 32'd20 : 32'd1000,
                    (c < 8) ? (32'h100 + c) : 32'h1FF, 1'b0, 32'd0, 32'd0);
      @(negedge Clk);
      if (c == 20) begin
        checkOutput("popFullAReady", {63'd0, bus.AReady}, 64'd0);
        checkOutput("popFullFlag", {63'd0, Full}, 64'd1);
      end
      if (c == 21) begin
        checkOutput("afterPopAReady", {63'd0, bus.AReady}, 64'd1);
        checkOutput("afterPopFull", {63'd0, Full}, 64'd0);
        checkOutput("afterPopDisp", {32'd0, DispValOut}, 64'h100);
      end
      if (c == 22) checkOutput("refillFull", {63'd0, Full}, 64'd1);
      nextCycle();
    end

    // Three equal-time entries release on consecutive cycles, in order
    doReset();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(c < 3, 32'd10, c + 1, 1'b0, 32'd0, 32'd0);
      @(negedge Clk);
      if (c == 10) checkOutput("eqDisp10", {32'd0, DispValOut}, 64'd0);
      if (c == 11) checkOutput("eqDisp11", {32'd0, DispValOut}, 64'd1);
      if (c == 12) checkOutput("eqDisp12", {32'd0, DispValOut}, 64'd2);
      if (c == 13) checkOutput("eqDisp13", {32'd0, DispValOut}, 64'd3);
      nextCycle();
    end

    // Out-of-order pair: Time=20 then Time=15
    doReset();
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c < 2, (c == 0) ? 32'd20 : 32'd15,
                    (c == 0) ? 32'h20 : 32'h15, 1'b0, 32'd0, 32'd0);
      @(negedge Clk);
      if (c == 1) checkOutput("ordAReady", {63'd0, bus.AReady}, 64'd1);
      if (c == 21) checkOutput("ordDisp21", {32'd0, DispValOut}, 64'h20);
`ifdef DISP_SCHED_ORDER_CHECK_EN
      if (c == 2)  checkOutput("ordErrPulse", {63'd0, Err}, 64'd1);
      if (c == 3)  checkOutput("ordErrDrop", {63'd0, Err}, 64'd0);
      if (c == 21) checkOutput("ordEmpty21", {63'd0, Empty}, 64'd1);
      if (c == 22) checkOutput("ordDisp22", {32'd0, DispValOut}, 64'h20);
`else
      if (c == 2)  checkOutput("ordErrTied", {63'd0, Err}, 64'd0);
      if (c == 21) checkOutput("ordEmpty21", {63'd0, Empty}, 64'd0);
      if (c == 22) checkOutput("ordDisp22", {32'd0, DispValOut}, 64'h15);
`endif
      if (c == 22) checkOutput("ordEmpty22", {63'd0, Empty}, 64'd1);
      nextCycle();
    end

    // Reset with four entries queued at CycleNo=50 flushes them all
    doReset();
    for (int c = 0; c < 61; c++) begin
      Reset = (c == 50);
      applyStimulus(1'b0, 32'd0, 32'd0, (c < 4) || (c == 50), 32'd1000, 32'h300 + c);
      @(negedge Clk);
      if (c == 49) checkOutput("preRstEmpty", {63'd0, Empty}, 64'd0);
      if (c == 50) begin
        checkOutput("rstCycleNo50", {32'd0, CycleNo}, 64'd50);
        checkOutput("rstBReady", {63'd0, bus.BReady}, 64'd0);
      end
      if (c == 51) begin
        checkOutput("postRstEmpty", {63'd0, Empty}, 64'd1);
        checkOutput("postRstCycle", {32'd0, CycleNo}, 64'd0);
        checkOutput("postRstDisp", {32'd0, DispValOut}, 64'd0);
      end
      if (c == 60) checkOutput("flushedDisp", {32'd0, DispValOut}, 64'd0);
      nextCycle();
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
